// File: rtl/mux4_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_seq_pkg
//  Description : Shared types, sizes and round-robin helper for the 4:1 mux
//                sequencer family.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux4_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        WAIT    = 2'd3
    } state_t;

    // First set bit searching last+1, last+2, ... wrapping; returns last if none set.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [SEL_W-1:0]  last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_pick
//  Description : Combinational 4-way round-robin priority picker.
//                MUX4_SEQ_CH0_PRIORITY_EN gives channel 0 absolute priority,
//                with channels 1-3 rotating among themselves.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_pick
    import mux4_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  ch,
    output logic              any
);

`ifdef MUX4_SEQ_CH0_PRIORITY_EN
    localparam logic [NUM_CH-1:0] c_upper_mask = {{(NUM_CH-1){1'b1}}, 1'b0};

    always_comb begin
        ch = '0;
        if (!req[0]) begin
            ch = rr_pick(req & c_upper_mask, last);
        end
    end
`else
    always_comb begin
        ch = rr_pick(req, last);
    end
`endif

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/mux4_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux4_rr_sequencer
//  Description : Round-robin scan of four requests driving 4:1 mux selects,
//                settle-then-capture of mux_out, valid/ready result with ack.
//                Optional macro: MUX4_SEQ_CH0_PRIORITY_EN (channel 0 priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_sequencer
    import mux4_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              mux_out,
    output logic              s1,
    output logic              s0,
    output logic [NUM_CH-1:0] ack,
    output logic              out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0]  c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [NUM_CH-1:0] c_one_hot0    = {{(NUM_CH-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_last, w_last_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [SEL_W-1:0]   r_ch, w_ch_nxt;
    logic               r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic [NUM_CH-1:0]  r_ack, w_ack_nxt;
    logic [SEL_W-1:0]   w_pick_ch;
    logic               w_pick_any;

    mux4_rr_pick u_pick (
        .req  (req),
        .last (r_last),
        .ch   (w_pick_ch),
        .any  (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= SEL_W'(NUM_CH - 1);
            r_sel   <= '0;
            r_ch    <= '0;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_ch    <= w_ch_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        w_ch_nxt    = r_ch;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_ack_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_sel_nxt   = w_pick_ch;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // A withdrawn request abandons the slot without touching fairness state.
                if (!req[r_sel]) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_settle_last) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_data_nxt  = mux_out;
                w_ch_nxt    = r_sel;
                w_valid_nxt = 1'b1;
                w_ack_nxt   = c_one_hot0 << r_sel;
                w_last_nxt  = r_sel;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign s1        = r_sel[1];
    assign s0        = r_sel[0];
    assign ack       = r_ack;
    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux4_rr_sequencer
//  Description : Directed scoreboard bench for mux4_rr_sequencer with a
//                behavioural 4:1 mux feeding mux_out (SETTLE 1 and 4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux4_rr_sequencer;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] a_req, a_in, a_ack;
    logic       a_mux, a_s1, a_s0, a_data, a_valid, a_rdy;
    logic [1:0] a_ch;

    logic [3:0] b_req, b_in, b_ack;
    logic       b_mux, b_s1, b_s0, b_data, b_valid, b_rdy;
    logic [1:0] b_ch;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic       data;
    } xfer_t;
    xfer_t sb_q[$];

    always #5 clk = ~clk;

    assign a_mux = a_in[{a_s1, a_s0}];
    assign b_mux = b_in[{b_s1, b_s0}];

    mux4_rr_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(a_req), .mux_out(a_mux),
        .s1(a_s1), .s0(a_s0), .ack(a_ack), .out_data(a_data),
        .out_ch(a_ch), .out_valid(a_valid), .out_ready(a_rdy)
    );

    mux4_rr_sequencer #(.SETTLE_CYCLES(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(b_req), .mux_out(b_mux),
        .s1(b_s1), .s0(b_s0), .ack(b_ack), .out_data(b_data),
        .out_ch(b_ch), .out_valid(b_valid), .out_ready(b_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [3:0] in_vec);
        xfer_t e;
        e.ch   = ch;
        e.data = in_vec[ch];
        sb_q.push_back(e);
    endtask

    // Waits (bounded) for out_valid, then pops the scoreboard and checks the result.
    task automatic wait_xfer(input string tag, input bit use_b);
        xfer_t      e;
        int         k;
        logic [3:0] ack_o;
        logic [1:0] ch_o, sel_o;
        logic       data_o, valid_o;
        k = 0;
        while (!(use_b ? b_valid : a_valid) && k < 40) begin
            tick();
            k++;
        end
        valid_o = use_b ? b_valid : a_valid;
        ack_o   = use_b ? b_ack : a_ack;
        ch_o    = use_b ? b_ch : a_ch;
        sel_o   = use_b ? {b_s1, b_s0} : {a_s1, a_s0};
        data_o  = use_b ? b_data : a_data;
        chk({tag, "_valid"}, 8'(valid_o), 8'd1);
        n_vec++;
        assert (sb_q.size() != 0) else begin
            n_bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_ch"},   8'(ch_o),   8'(e.ch));
            chk({tag, "_sel"},  8'(sel_o),  8'(e.ch));
            chk({tag, "_data"}, 8'(data_o), 8'(e.data));
            chk({tag, "_ack"},  8'(ack_o),  8'(4'b0001 << e.ch));
        end
    endtask

    task automatic accept_a(input string tag);
        tick();
        chk({tag, "_drop"},    8'(a_valid), 8'd0);
        chk({tag, "_ack1cyc"}, 8'(a_ack),   8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        a_req = '0; a_in = '0; a_rdy = 1'b0;
        b_req = '0; b_in = '0; b_rdy = 1'b0;
        tick();
        tick();

        // Reset state of both instances
        chk("rst_a_sel",   8'({a_s1, a_s0}), 8'd0);
        chk("rst_a_ack",   8'(a_ack),   8'd0);
        chk("rst_a_data",  8'(a_data),  8'd0);
        chk("rst_a_ch",    8'(a_ch),    8'd0);
        chk("rst_a_valid", 8'(a_valid), 8'd0);
        chk("rst_b_valid", 8'(b_valid), 8'd0);
        chk("rst_b_ack",   8'(b_ack),   8'd0);

        // Single request, exact cycle timing with SETTLE_CYCLES=1
        rst   = 1'b0;
        a_req = 4'b0001; a_in = 4'b0001; a_rdy = 1'b1;
        push(2'd0, a_in);
        tick();
        chk("t1_c1_sel",   8'({a_s1, a_s0}), 8'd0);
        chk("t1_c1_valid", 8'(a_valid), 8'd0);
        tick();
        chk("t1_c2_valid", 8'(a_valid), 8'd0);
        chk("t1_c2_ack",   8'(a_ack),   8'd0);
        tick();
        chk("t1_c3_valid_now", 8'(a_valid), 8'd1);
        wait_xfer("t1", 1'b0);
        a_req = 4'b0000;
        accept_a("t1_c4");

        // All four requesting: strict rotation from reset
        a_req = 4'b0000;
        do_reset();
        a_req = 4'b1111; a_in = 4'b1010;
        push(2'd0, a_in); push(2'd1, a_in); push(2'd2, a_in);
        push(2'd3, a_in); push(2'd0, a_in);
        for (int i = 0; i < 5; i++) begin
            wait_xfer("t2_rr", 1'b0);
            if (i == 4) a_req = 4'b0000;
            accept_a("t2_rr");
        end

        // Back-pressure: result and selects frozen while mux_out toggles
        a_req = 4'b0100; a_in = 4'b0100; a_rdy = 1'b0;
        push(2'd2, a_in);
        wait_xfer("t3", 1'b0);
        for (int i = 0; i < 10; i++) begin
            a_in[2] = ~a_in[2];
            tick();
            chk("t3_hold_valid", 8'(a_valid), 8'd1);
            chk("t3_hold_data",  8'(a_data),  8'd1);
            chk("t3_hold_ch",    8'(a_ch),    8'd2);
            chk("t3_hold_sel",   8'({a_s1, a_s0}), 8'd2);
            chk("t3_hold_ack",   8'(a_ack),   8'd0);
        end
        a_rdy = 1'b1; a_req = 4'b0000;
        accept_a("t3");
        tick();
        chk("t3_single", 8'(a_valid), 8'd0);

        // SETTLE_CYCLES=4: request withdrawn in the 2nd settle cycle
        b_rdy = 1'b1; b_in = 4'b0100; b_req = 4'b0100;
        tick();
        chk("t4_sel", 8'({b_s1, b_s0}), 8'd2);
        tick();
        b_req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_abort_valid", 8'(b_valid), 8'd0);
            chk("t4_abort_ack",   8'(b_ack),   8'd0);
        end
        b_req = 4'b0100;
        push(2'd2, b_in);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t4_latency", 8'(b_valid), 8'd0);
        end
        tick();
        wait_xfer("t4", 1'b1);
        b_req = 4'b0000;
        tick();
        chk("t4_drop", 8'(b_valid), 8'd0);
        chk("t4_ack1cyc", 8'(b_ack), 8'd0);

        // Reset while holding a result in WAIT
        a_rdy = 1'b0; a_req = 4'b0010; a_in = 4'b0010;
        push(2'd1, a_in);
        wait_xfer("t5_pre", 1'b0);
        rst = 1'b1;
        tick();
        chk("t5_rst_valid", 8'(a_valid), 8'd0);
        chk("t5_rst_sel",   8'({a_s1, a_s0}), 8'd0);
        chk("t5_rst_ack",   8'(a_ack),   8'd0);
        chk("t5_rst_data",  8'(a_data),  8'd0);
        rst = 1'b0;
        a_req = 4'b1010; a_rdy = 1'b1; a_in = 4'b1000;
        push(2'd1, a_in); push(2'd3, a_in);
        wait_xfer("t5_first", 1'b0);
        accept_a("t5_first");
        wait_xfer("t5_second", 1'b0);
        a_req = 4'b0000;
        accept_a("t5_second");

        // req=1011 held: pure rotation vs channel-0 priority
        do_reset();
        a_req = 4'b1011; a_in = 4'b1001;
`ifdef MUX4_SEQ_CH0_PRIORITY_EN
        push(2'd0, a_in); push(2'd0, a_in); push(2'd0, a_in); push(2'd0, a_in);
`else
        push(2'd0, a_in); push(2'd1, a_in); push(2'd3, a_in); push(2'd0, a_in);
`endif
        for (int i = 0; i < 4; i++) begin
            wait_xfer("t6_order", 1'b0);
            if (i == 3) a_req = 4'b0000;
            accept_a("t6_order");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
